adc_cal_protect: RTL and testbench

- Sits directly downstream of the 4-channel sigma-delta ADC peripheral. Consumes its per-channel 16-bit results and one-cycle valid strobes.
- Per channel: applies offset and gain calibration, then checks the result against programmable window limits with a debounce counter.
- Drives a latched hardware fault trip toward the PWM/inverter protection path.
- Exposes configuration and calibrated results on the Wishbone bus. A single shared arithmetic pipeline is time-multiplexed across channels.

---
 rtl/adc_cal_protect.sv | 275 +++++++++++++++++++++++++++
 tb/tb_adc_cal_protect.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_cal_protect.sv
`default_nettype none
// ============================================================================
// Module   : adc_cal_protect
// Purpose  : 4-channel ADC offset/gain calibration with debounced window
//            fault trip, configured over Wishbone.
// Revision : 1.0  initial release
// ============================================================================
module adc_cal_protect #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEBOUNCE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_we,
    input  logic [3:0]            wb_sel,
    input  logic                  wb_stb,
    output logic                  wb_ack,
    input  logic [63:0]           adc_data,
    input  logic [3:0]            adc_valid,
    output logic [63:0]           cal_data,
    output logic [3:0]            cal_valid,
    output logic                  fault_trip,
    output logic                  irq
);

    localparam int         c_num_ch   = 4;
    localparam logic [3:0] c_debounce = 4'(DEBOUNCE);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SUB  = 3'd1,
        S_MUL  = 3'd2,
        S_SAT  = 3'd3,
        S_CMP  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Configuration
    logic               r_enable;
    logic [15:0]        r_offset [c_num_ch];
    logic [15:0]        r_gain   [c_num_ch];
    logic signed [15:0] r_hi     [c_num_ch];
    logic signed [15:0] r_lo     [c_num_ch];

    // Capture, status and outputs
    logic [15:0]        r_hold   [c_num_ch];
    logic [3:0]         r_pend;
    logic [3:0]         r_fault;
    logic [3:0]         r_dbc    [c_num_ch];
    logic signed [15:0] r_cal    [c_num_ch];
    logic [3:0]         r_cal_valid;
    logic               r_irq;
    logic               r_fault_trip;
    logic               r_ack;
    logic [31:0]        r_rdata;

    // Work registers for the sample in flight
    logic [1:0]         r_ch;
    logic [15:0]        r_raw;
    logic [15:0]        r_off_w;
    logic [15:0]        r_gain_w;
    logic signed [15:0] r_hi_w;
    logic signed [15:0] r_lo_w;
    logic signed [16:0] r_d;
    logic signed [32:0] r_p;
    logic signed [15:0] r_r;

    logic               w_sel_any;
    logic [1:0]         w_sel_ch;
    logic               w_take;
    logic [3:0]         w_pend_next;
    logic               w_wr;
    logic [5:0]         w_idx;
    logic               w_clear;
    logic [31:0]        w_rdata;
    logic signed [16:0] w_diff;
    logic signed [33:0] w_prod;
    logic signed [32:0] w_shift;
    logic signed [15:0] w_sat;
    logic               w_out_win;
    logic [3:0]         w_dbc_inc;
    logic [3:0]         w_dbc_next [c_num_ch];
    logic [3:0]         w_fault_next;
    logic               w_irq_next;

    wire w_unused = &{1'b0, wb_sel, wb_addr, w_prod[33]};

    assign wb_dat_o   = r_rdata;
    assign wb_ack     = r_ack;
    assign cal_valid  = r_cal_valid;
    assign fault_trip = r_fault_trip;
    assign irq        = r_irq;

    generate
        for (genvar g = 0; g < c_num_ch; g++) begin : g_pack
            assign cal_data[16*g +: 16] = r_cal[g];
        end
    endgenerate

    // Lowest-index pending channel wins
    always_comb begin
        w_sel_any = |r_pend;
        w_sel_ch  = 2'd0;
        for (int n = c_num_ch - 1; n >= 0; n--) begin
            if (r_pend[n]) w_sel_ch = n[1:0];
        end
    end

    assign w_take = (r_state == S_IDLE) && r_enable && w_sel_any;

    always_comb begin
        w_pend_next = r_pend;
        if (w_take) w_pend_next[w_sel_ch] = 1'b0;
        w_pend_next = w_pend_next | adc_valid;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_take) w_state_next = S_SUB;
            S_SUB:   w_state_next = S_MUL;
            S_MUL:   w_state_next = S_SAT;
            S_SAT:   w_state_next = S_CMP;
            S_CMP:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Arithmetic stages
    assign w_diff  = $signed({1'b0, r_raw}) - $signed({r_off_w[15], r_off_w});
    assign w_prod  = r_d * $signed({1'b0, r_gain_w});
    assign w_shift = r_p >>> 15;

    always_comb begin
        if (w_shift > 33'sd32767)       w_sat = 16'sh7FFF;
        else if (w_shift < -33'sd32768) w_sat = -16'sh8000;
        else                            w_sat = w_shift[15:0];
    end

    assign w_out_win = (r_r > r_hi_w) || (r_r < r_lo_w);

    assign w_wr    = wb_stb && !r_ack && wb_we;
    assign w_idx   = wb_addr[7:2];
    assign w_clear = w_wr && (w_idx == 6'd0) && wb_dat_i[1];

    // Clear is applied first so that a same-cycle trip overrides it
    always_comb begin
        w_fault_next = r_fault;
        w_irq_next   = 1'b0;
        w_dbc_inc    = 4'd0;
        for (int n = 0; n < c_num_ch; n++) w_dbc_next[n] = r_dbc[n];
        if (w_clear) begin
            w_fault_next = 4'd0;
            for (int n = 0; n < c_num_ch; n++) w_dbc_next[n] = 4'd0;
        end
        if (r_state == S_CMP) begin
            if (w_out_win) begin
                w_dbc_inc = (r_dbc[r_ch] == 4'hF) ? 4'hF : r_dbc[r_ch] + 4'd1;
                w_dbc_next[r_ch] = w_dbc_inc;
                if (w_dbc_inc >= c_debounce) begin
                    w_fault_next[r_ch] = 1'b1;
                    w_irq_next         = !r_fault[r_ch];
                end
            end else begin
                w_dbc_next[r_ch] = 4'd0;
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (w_idx[5:2])
            4'd0: begin
                if (w_idx[1:0] == 2'd0) w_rdata = {31'd0, r_enable};
                if (w_idx[1:0] == 2'd1) w_rdata = {24'd0, r_pend, r_fault};
            end
            4'd1:    w_rdata = {r_gain[w_idx[1:0]], r_offset[w_idx[1:0]]};
            4'd2:    w_rdata = {r_hi[w_idx[1:0]], r_lo[w_idx[1:0]]};
            4'd3:    w_rdata = {{16{r_cal[w_idx[1:0]][15]}}, r_cal[w_idx[1:0]]};
            default: w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable     <= 1'b0;
            r_pend       <= 4'd0;
            r_fault      <= 4'd0;
            r_cal_valid  <= 4'd0;
            r_irq        <= 1'b0;
            r_fault_trip <= 1'b0;
            r_ack        <= 1'b0;
            r_rdata      <= 32'd0;
            r_ch         <= 2'd0;
            r_raw        <= 16'd0;
            r_off_w      <= 16'd0;
            r_gain_w     <= 16'h8000;
            r_hi_w       <= 16'sh7FFF;
            r_lo_w       <= -16'sh8000;
            r_d          <= 17'sd0;
            r_p          <= 33'sd0;
            r_r          <= 16'sd0;
            for (int n = 0; n < c_num_ch; n++) begin
                r_offset[n] <= 16'd0;
                r_gain[n]   <= 16'h8000;
                r_hi[n]     <= 16'sh7FFF;
                r_lo[n]     <= -16'sh8000;
                r_hold[n]   <= 16'd0;
                r_dbc[n]    <= 4'd0;
                r_cal[n]    <= 16'sd0;
            end
        end else begin
            r_ack <= wb_stb && !r_ack;
            if (wb_stb && !r_ack) r_rdata <= w_rdata;

            if (w_wr) begin
                case (w_idx[5:2])
                    4'd0: if (w_idx[1:0] == 2'd0) r_enable <= wb_dat_i[0];
                    4'd1: begin
                        r_gain[w_idx[1:0]]   <= wb_dat_i[31:16];
                        r_offset[w_idx[1:0]] <= wb_dat_i[15:0];
                    end
                    4'd2: begin
                        r_hi[w_idx[1:0]] <= wb_dat_i[31:16];
                        r_lo[w_idx[1:0]] <= wb_dat_i[15:0];
                    end
                    default: ;
                endcase
            end

            for (int n = 0; n < c_num_ch; n++) begin
                if (adc_valid[n]) r_hold[n] <= adc_data[16*n +: 16];
                r_dbc[n] <= w_dbc_next[n];
            end
            r_pend       <= w_pend_next;
            r_fault      <= w_fault_next;
            r_fault_trip <= |w_fault_next;
            r_irq        <= w_irq_next;
            r_cal_valid  <= 4'd0;

            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_ch     <= w_sel_ch;
                        r_raw    <= r_hold[w_sel_ch];
                        r_off_w  <= r_offset[w_sel_ch];
                        r_gain_w <= r_gain[w_sel_ch];
                        r_hi_w   <= r_hi[w_sel_ch];
                        r_lo_w   <= r_lo[w_sel_ch];
                    end
                end
                S_SUB: r_d <= w_diff;
                S_MUL: r_p <= w_prod[32:0];
                S_SAT: r_r <= w_sat;
                S_CMP: begin
                    r_cal[r_ch]       <= r_r;
                    r_cal_valid[r_ch] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_cal_protect.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_cal_protect
// Purpose  : Directed self-checking bench for adc_cal_protect.
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_cal_protect;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  wb_addr;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_stb;
    logic        wb_ack;
    logic [63:0] adc_data;
    logic [3:0]  adc_valid;
    logic [63:0] cal_data;
    logic [3:0]  cal_valid;
    logic        fault_trip;
    logic        irq;

    int          n_cmp     = 0;
    int          n_fail    = 0;
    int          irq_count = 0;
    logic [31:0] rd;
    int          cyc;
    logic [15:0] v;

    adc_cal_protect #(.ADDR_WIDTH(8), .DEBOUNCE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_addr    (wb_addr),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_we      (wb_we),
        .wb_sel     (wb_sel),
        .wb_stb     (wb_stb),
        .wb_ack     (wb_ack),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .cal_data   (cal_data),
        .cal_valid  (cal_valid),
        .fault_trip (fault_trip),
        .irq        (irq)
    );

    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [7:0] addr, input logic [31:0] data);
        wb_addr  = addr;
        wb_dat_i = data;
        wb_we    = 1'b1;
        wb_stb   = 1'b1;
        tick();
        wb_stb   = 1'b0;
        wb_we    = 1'b0;
        tick();
    endtask

    task automatic wb_read(input logic [7:0] addr, output logic [31:0] data);
        wb_addr = addr;
        wb_we   = 1'b0;
        wb_stb  = 1'b1;
        tick();
        data    = wb_dat_o;
        wb_stb  = 1'b0;
        tick();
    endtask

    task automatic adc_strobe(input int ch, input logic [15:0] val);
        adc_data[16*ch +: 16] = val;
        adc_valid             = 4'd0;
        adc_valid[ch]         = 1'b1;
        tick();
        adc_valid             = 4'd0;
    endtask

    // Returns the tick count at which cal_valid[ch] was seen, or -1
    task automatic wait_cal(input int ch, output int cycles, output logic [15:0] val);
        int t;
        cycles = -1;
        val    = 16'd0;
        t      = 0;
        while (cycles < 0 && t < 40) begin
            tick();
            t++;
            if (irq) irq_count++;
            if (cal_valid[ch]) begin
                cycles = t;
                val    = cal_data[16*ch +: 16];
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        wb_addr   = 8'd0;
        wb_dat_i  = 32'd0;
        wb_we     = 1'b0;
        wb_sel    = 4'hF;
        wb_stb    = 1'b0;
        adc_data  = 64'd0;
        adc_valid = 4'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (cal_data !== 64'd0) begin n_fail++; $display("FAIL reset_cal_data: got %h expected 0", cal_data); end
        n_cmp++; if (cal_valid !== 4'd0) begin n_fail++; $display("FAIL reset_cal_valid: got %h expected 0", cal_valid); end
        n_cmp++; if (fault_trip !== 1'b0) begin n_fail++; $display("FAIL reset_fault_trip: got %b expected 0", fault_trip); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        n_cmp++; if (wb_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", wb_ack); end
        wb_addr = 8'h10; wb_we = 1'b0; wb_stb = 1'b1;
        tick();
        n_cmp++; if (wb_ack !== 1'b1) begin n_fail++; $display("FAIL ack_high: got %b expected 1", wb_ack); end
        n_cmp++; if (wb_dat_o !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_cal0: got %h expected 80000000", wb_dat_o); end
        wb_stb = 1'b0;
        tick();
        n_cmp++; if (wb_ack !== 1'b0) begin n_fail++; $display("FAIL ack_low: got %b expected 0", wb_ack); end
        wb_read(8'h20, rd);
        n_cmp++; if (rd !== 32'h7FFF_8000) begin n_fail++; $display("FAIL reset_lim0: got %h expected 7fff8000", rd); end
        wb_read(8'h08, rd);
        n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", rd); end
        wb_read(8'h00, rd);
        n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", rd); end
    endtask

    task automatic test_enable_gate();
        int seen;
        seen = 0;
        adc_strobe(0, 16'h0042);
        for (int t = 0; t < 8; t++) begin
            tick();
            if (cal_valid !== 4'd0) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL disabled_no_valid: got %0d expected 0", seen); end
        wb_read(8'h04, rd);
        n_cmp++; if (rd !== 32'h0000_0010) begin n_fail++; $display("FAIL pend_visible: got %h expected 00000010", rd); end
        wb_write(8'h00, 32'h1);
        wait_cal(0, cyc, v);
        n_cmp++; if (v !== 16'h0042 || cyc < 0) begin n_fail++; $display("FAIL enable_release: got %h (t=%0d) expected 0042", v, cyc); end
    endtask

    task automatic test_passthrough();
        adc_strobe(0, 16'h1234);
        wait_cal(0, cyc, v);
        n_cmp++; if (cyc !== 5) begin n_fail++; $display("FAIL latency: got %0d expected 5", cyc); end
        n_cmp++; if (v !== 16'h1234) begin n_fail++; $display("FAIL unity_cal: got %h expected 1234", v); end
        n_cmp++; if (cal_valid !== 4'b0001) begin n_fail++; $display("FAIL valid_onehot: got %b expected 0001", cal_valid); end
        n_cmp++; if (fault_trip !== 1'b0) begin n_fail++; $display("FAIL no_trip: got %b expected 0", fault_trip); end
        tick();
        n_cmp++; if (cal_valid !== 4'b0000) begin n_fail++; $display("FAIL valid_pulse: got %b expected 0000", cal_valid); end
        wb_read(8'h30, rd);
        n_cmp++; if (rd !== 32'h0000_1234) begin n_fail++; $display("FAIL data0_read: got %h expected 00001234", rd); end
    endtask

    task automatic test_gain_offset();
        wb_write(8'h18, 32'h4000_0100);
        adc_strobe(2, 16'h2100);
        wait_cal(2, cyc, v);
        n_cmp++; if (v !== 16'h1000) begin n_fail++; $display("FAIL half_gain: got %h expected 1000", v); end
        wb_write(8'h18, 32'hFFFF_0100);
        adc_strobe(2, 16'hFFFF);
        wait_cal(2, cyc, v);
        n_cmp++; if (v !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos: got %h expected 7fff", v); end
        wb_write(8'h18, 32'hFFFF_7FFF);
        adc_strobe(2, 16'h0000);
        wait_cal(2, cyc, v);
        n_cmp++; if (v !== 16'h8000) begin n_fail++; $display("FAIL sat_neg: got %h expected 8000", v); end
        wb_write(8'h18, 32'h8000_0100);
        adc_strobe(2, 16'h0000);
        wait_cal(2, cyc, v);
        n_cmp++; if (v !== 16'hFF00) begin n_fail++; $display("FAIL negative: got %h expected ff00", v); end
        wb_read(8'h38, rd);
        n_cmp++; if (rd !== 32'hFFFF_FF00) begin n_fail++; $display("FAIL data2_sext: got %h expected ffffff00", rd); end
    endtask

    task automatic test_back_to_back();
        int          seen_t [4];
        logic [15:0] seen_v [4];
        logic [15:0] exp_v  [4];
        exp_v = '{16'h0111, 16'h0222, 16'h0333, 16'h0088};
        for (int c = 0; c < 4; c++) begin seen_t[c] = -1; seen_v[c] = 16'd0; end
        wb_write(8'h18, 32'h8000_0000);
        wb_write(8'h1C, 32'h4000_FFF0);
        adc_data  = {16'h0100, 16'h0333, 16'h0222, 16'h0111};
        adc_valid = 4'hF;
        tick();
        adc_valid = 4'h0;
        for (int t = 1; t <= 25; t++) begin
            tick();
            for (int c = 0; c < 4; c++) begin
                if (cal_valid[c]) begin
                    seen_t[c] = t;
                    seen_v[c] = cal_data[16*c +: 16];
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (seen_t[c] !== 5 * (c + 1)) begin n_fail++; $display("FAIL b2b_time_ch%0d: got %0d expected %0d", c, seen_t[c], 5 * (c + 1)); end
            n_cmp++; if (seen_v[c] !== exp_v[c]) begin n_fail++; $display("FAIL b2b_value_ch%0d: got %h expected %h", c, seen_v[c], exp_v[c]); end
        end
    endtask

    task automatic test_debounce();
        int   smp [7];
        logic exp_trip;
        smp = '{1200, 1200, 900, 1200, 1200, 1200, 1200};
        irq_count = 0;
        wb_write(8'h24, 32'h03E8_8000);
        for (int k = 0; k < 7; k++) begin
            adc_strobe(1, smp[k][15:0]);
            wait_cal(1, cyc, v);
            exp_trip = (k == 6);
            n_cmp++; if (fault_trip !== exp_trip) begin n_fail++; $display("FAIL debounce_step%0d: got %b expected %b", k, fault_trip, exp_trip); end
        end
        wb_read(8'h04, rd);
        n_cmp++; if (rd !== 32'h0000_0002) begin n_fail++; $display("FAIL fault_reg: got %h expected 00000002", rd); end
        n_cmp++; if (irq_count !== 1) begin n_fail++; $display("FAIL irq_count: got %0d expected 1", irq_count); end
    endtask

    task automatic test_clear_and_reset();
        int seen;
        n_cmp++; if (fault_trip !== 1'b1) begin n_fail++; $display("FAIL pre_clear_trip: got %b expected 1", fault_trip); end
        wb_addr = 8'h00; wb_dat_i = 32'h3; wb_we = 1'b1; wb_stb = 1'b1;
        tick();
        n_cmp++; if (fault_trip !== 1'b0) begin n_fail++; $display("FAIL clear_trip: got %b expected 0", fault_trip); end
        wb_stb = 1'b0; wb_we = 1'b0;
        tick();
        wb_read(8'h04, rd);
        n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL clear_fault_reg: got %h expected 0", rd); end
        wb_read(8'h00, rd);
        n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL clear_keeps_enable: got %h expected 1", rd); end

        adc_strobe(0, 16'h0555);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        seen = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (cal_valid !== 4'd0) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d expected 0", seen); end
        n_cmp++; if (cal_data !== 64'd0) begin n_fail++; $display("FAIL abort_cal_data: got %h expected 0", cal_data); end
        wb_read(8'h1C, rd);
        n_cmp++; if (rd !== 32'h8000_0000) begin n_fail++; $display("FAIL abort_cal3: got %h expected 80000000", rd); end
        wb_read(8'h24, rd);
        n_cmp++; if (rd !== 32'h7FFF_8000) begin n_fail++; $display("FAIL abort_lim1: got %h expected 7fff8000", rd); end
        wb_read(8'h00, rd);
        n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL abort_ctrl: got %h expected 0", rd); end
        wb_read(8'h30, rd);
        n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL abort_data0: got %h expected 0", rd); end
    endtask

    initial begin
        test_reset();
        test_enable_gate();
        test_passthrough();
        test_gain_offset();
        test_back_to_back();
        test_debounce();
        test_clear_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
